// File: rtl/bram_wr_sched_pkg.sv
// Shared types and constants for the two-channel BRAM write scheduler.
package bram_wr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam int NUM_CH       = 2;
    localparam int YIELD_CYCLES = 16;

    // Round-robin pick: the pointer channel wins when active, otherwise the other one.
    function automatic logic rr_pick(input logic [NUM_CH-1:0] act, input logic rr);
        return act[rr] ? rr : ~rr;
    endfunction

endpackage

// File: rtl/bram_wr_ctx.sv
// Per-channel write context: command capture, running address, remaining beats, done pulse.
module bram_wr_ctx
    import bram_wr_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              aclk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              beat_i,
    output logic              active_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no latch is inferred.
        active_d = active_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        if (cmd_valid_i && !active_q) begin
            addr_d   = cmd_base_i;
            rem_d    = cmd_len_i;
            active_d = (cmd_len_i != '0);
            done_d   = (cmd_len_i == '0);
        end else if (beat_i && active_q) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge aclk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready_o = ~active_q;
    assign active_o    = active_q;
    assign addr_o      = addr_q;
    assign last_o      = (rem_q == LEN_W'(1));
    assign done_o      = done_q;

endmodule

// File: rtl/bram_wr_sched.sv
// Round-robin two-channel scheduler sharing one BRAM write port in bounded bursts.
// Optional BRAM_WR_SCHED_YIELD_EN: a stalled grant yields after YIELD_CYCLES idle cycles.
module bram_wr_sched
    import bram_wr_sched_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [1:0]            cmd_valid,
    output logic [1:0]            cmd_ready,
    input  logic [2*ADDR_W-1:0]   cmd_base,
    input  logic [2*LEN_W-1:0]    cmd_len,
    input  logic [1:0]            s_tvalid,
    output logic [1:0]            s_tready,
    input  logic [2*DATA_W-1:0]   s_tdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    output logic [1:0]            done,
    output logic                  busy
);

    localparam int BEAT_W = $clog2(MAX_BURST);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_q, rr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                burst_end;
    logic                fire;
    logic [NUM_CH-1:0]   beat_fire;
    logic [NUM_CH-1:0]   ctx_active;
    logic [NUM_CH-1:0]   ctx_last;
    logic [ADDR_W-1:0]   ctx_addr [NUM_CH];
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_din_q;
    logic [DATA_W-1:0]   grant_data;

`ifdef BRAM_WR_SCHED_YIELD_EN
    localparam int IDLE_W = $clog2(YIELD_CYCLES);
    logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bram_wr_ctx #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_ctx (
            .aclk_i      (aclk),
            .rst_i       (rst),
            .cmd_valid_i (cmd_valid[c]),
            .cmd_ready_o (cmd_ready[c]),
            .cmd_base_i  (cmd_base[c*ADDR_W +: ADDR_W]),
            .cmd_len_i   (cmd_len[c*LEN_W +: LEN_W]),
            .beat_i      (beat_fire[c]),
            .active_o    (ctx_active[c]),
            .addr_o      (ctx_addr[c]),
            .last_o      (ctx_last[c]),
            .done_o      (done[c])
        );
    end

    assign fire       = (state_q == ST_BURST) && ctx_active[grant_q] && s_tvalid[grant_q];
    assign beat_fire  = {fire & grant_q, fire & ~grant_q};
    assign grant_data = grant_q ? s_tdata[2*DATA_W-1:DATA_W] : s_tdata[DATA_W-1:0];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        s_tready  = '0;
        burst_end = 1'b0;
`ifdef BRAM_WR_SCHED_YIELD_EN
        idle_d    = idle_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|ctx_active) state_d = ST_ARB;
            end
            ST_ARB: begin
                beat_d = '0;
`ifdef BRAM_WR_SCHED_YIELD_EN
                idle_d = '0;
`endif
                if (|ctx_active) begin
                    grant_d = rr_pick(ctx_active, rr_q);
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                // Leaving BURST on the ending handshake lowers s_tready before another beat.
                s_tready[grant_q] = ctx_active[grant_q];
                if (fire) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (ctx_last[grant_q] || beat_q == BEAT_W'(MAX_BURST - 1)) burst_end = 1'b1;
                end
`ifdef BRAM_WR_SCHED_YIELD_EN
                if (fire) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(YIELD_CYCLES - 1)) begin
                    burst_end = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
`endif
                if (burst_end) begin
                    rr_d    = ~grant_q;
                    state_d = (ctx_active[~grant_q] || !(fire && ctx_last[grant_q])) ? ST_ARB
                                                                                     : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

`ifdef BRAM_WR_SCHED_YIELD_EN
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`endif

    // NOTE: the write-data registers are reset too, since every output must read 0 in reset.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_din_q  <= '0;
        end else begin
            wr_en_q <= fire;
            if (fire) begin
                wr_addr_q <= ctx_addr[grant_q];
                wr_din_q  <= grant_data;
            end
        end
    end

    assign bram_en   = wr_en_q;
    assign bram_we   = wr_en_q;
    assign bram_addr = wr_addr_q;
    assign bram_din  = wr_din_q;
    assign busy      = (|ctx_active) | wr_en_q;

endmodule

// File: tb/tb_bram_wr_sched.sv
// Self-checking bench for bram_wr_sched: per-channel address/data scoreboard plus directed scenarios.
module tb_bram_wr_sched;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BURST = 16;

    logic                aclk = 1'b0;
    logic                rst  = 1'b1;
    logic [1:0]          cmd_valid = '0;
    logic [1:0]          cmd_ready;
    logic [2*ADDR_W-1:0] cmd_base = '0;
    logic [2*LEN_W-1:0]  cmd_len = '0;
    logic [1:0]          s_tvalid = '0;
    logic [1:0]          s_tready;
    logic [2*DATA_W-1:0] s_tdata = '0;
    logic                bram_en, bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [DATA_W-1:0]   bram_din;
    logic [1:0]          done;
    logic                busy;

    always #5 aclk = ~aclk;

    bram_wr_sched #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .aclk(aclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .done(done), .busy(busy)
    );

    typedef struct { int ch; int addr; } wr_t;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] stream [2][$];
    int idx[2], en[2], pct[2], base_m[2], len_m[2], wcnt[2], done_cnt[2];
    int pend_base[2], pend_len[2];
    int run_len, en_rises, total_writes;
    logic prev_en;
    wr_t wlog[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 2; c++) begin
            stream[c].delete();
            idx[c] = 0; en[c] = 0; pct[c] = 100;
            base_m[c] = 0; len_m[c] = 0; wcnt[c] = 0; done_cnt[c] = 0;
        end
        wlog.delete();
        run_len = 0; en_rises = 0; total_writes = 0; prev_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cmd_valid = '0;
        s_tvalid = '0;
        clear_model();
        repeat (2) @(posedge aclk);
        #1 rst = 1'b0;
    endtask

    // Channel tag lives in data bit 31 so the scoreboard can attribute each write.
    task automatic post(input int c, input int base, input int len, input bit ramp);
        stream[c].delete();
        for (int i = 0; i < len; i++)
            stream[c].push_back(ramp ? DATA_W'(i) : {c[0], 31'($urandom)});
        idx[c] = 0;
        pend_base[c] = base;
        pend_len[c] = len;
        cmd_base[c*ADDR_W +: ADDR_W] = ADDR_W'(base);
        cmd_len[c*LEN_W +: LEN_W] = LEN_W'(len);
        cmd_valid[c] = 1'b1;
    endtask

    task automatic sample();
        if (bram_en) begin
            int ch;
            int exp_addr;
            wr_t e;
            ch = int'(bram_din[DATA_W-1]);
            total_writes++;
            check("bram_we", bram_we, 1);
            check("write_in_cmd", wcnt[ch] < len_m[ch], 1);
            if (wcnt[ch] < len_m[ch]) begin
                exp_addr = (base_m[ch] + wcnt[ch]) % (1 << ADDR_W);
                check("bram_addr", bram_addr, exp_addr);
                check("bram_din", bram_din, stream[ch][wcnt[ch]]);
            end
            wcnt[ch]++;
            e.ch = ch;
            e.addr = int'(bram_addr);
            wlog.push_back(e);
            if (!prev_en) en_rises++;
            run_len = prev_en ? run_len + 1 : 1;
            check("burst_le_max", run_len <= MAX_BURST, 1);
        end
        prev_en = bram_en;
        for (int c = 0; c < 2; c++) begin
            if (done[c]) begin
                done_cnt[c]++;
                check("done_aligned", wcnt[c], len_m[c]);
            end
        end
    endtask

    task automatic cycle();
        bit hs[2];
        bit chs[2];
        @(negedge aclk);
        for (int c = 0; c < 2; c++) begin
            s_tvalid[c] = (en[c] != 0) && (idx[c] < stream[c].size()) && ($urandom_range(99) < pct[c]);
            s_tdata[c*DATA_W +: DATA_W] = (idx[c] < stream[c].size()) ? stream[c][idx[c]] : '0;
        end
        #1;
        for (int c = 0; c < 2; c++) begin
            hs[c]  = s_tvalid[c] & s_tready[c];
            chs[c] = cmd_valid[c] & cmd_ready[c];
        end
        @(posedge aclk);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (hs[c]) idx[c]++;
            if (chs[c]) begin
                cmd_valid[c] = 1'b0;
                base_m[c] = pend_base[c];
                len_m[c] = pend_len[c];
                wcnt[c] = 0;
            end
        end
        sample();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_done(input int c, input int target, input int budget);
        int n = 0;
        while (done_cnt[c] < target && n < budget) begin
            cycle();
            n++;
        end
        check("done_in_budget", done_cnt[c] >= target, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, t0, t1, l0, l1;
        int seg_ch[4], seg_base[4], seg_n[4];
        wr_t exp_q[$];
        wr_t e;

        clear_model();
        reset_dut();
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_din", bram_din, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_cmd_ready", cmd_ready, 2'b11);

        // Long ramp fill of words 32768..37567
        en[0] = 1;
        post(0, 32768, 4800, 1);
        wait_done(0, 1, 6000);
        check("t1_busy_at_done", busy, 1);
        cycle();
        check("t1_busy_after", busy, 0);
        run(4);
        check("t1_writes", wcnt[0], 4800);
        check("t1_done_once", done_cnt[0], 1);
        check("t1_bursts", en_rises, 300);
        if (wlog.size() > 0) check("t1_last_addr", wlog[wlog.size()-1].addr, 37567);

        // Both channels posted together: ch0 wins first, then strict alternation
        reset_dut();
        en = '{1, 1};
        post(0, 0, 20, 0);
        post(1, 100, 20, 0);
        wait_done(0, 1, 400);
        wait_done(1, 1, 400);
        run(3);
        seg_ch = '{0, 1, 0, 1};
        seg_base = '{0, 100, 16, 116};
        seg_n = '{16, 16, 4, 4};
        exp_q.delete();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < seg_n[s]; i++) begin
                e.ch = seg_ch[s];
                e.addr = seg_base[s] + i;
                exp_q.push_back(e);
            end
        check("t2_len", wlog.size(), 40);
        for (int i = 0; i < 40 && i < wlog.size(); i++) begin
            check("t2_order_ch", wlog[i].ch, exp_q[i].ch);
            check("t2_order_addr", wlog[i].addr, exp_q[i].addr);
        end
        check("t2_done0", done_cnt[0], 1);
        check("t2_done1", done_cnt[1], 1);

        // Zero-length command
        reset_dut();
        post(1, 5, 0, 0);
        cycle();
        check("t3_done", done, 2'b10);
        check("t3_ready", cmd_ready, 2'b11);
        cycle();
        check("t3_done_clear", done, 0);
        run(4);
        check("t3_no_write", total_writes, 0);
        check("t3_done_cnt", done_cnt[1], 1);
        check("t3_busy", busy, 0);

        // Address wrap
        reset_dut();
        en[0] = 1;
        post(0, 'hFFFE, 4, 0);
        wait_done(0, 1, 100);
        run(2);
        check("t4_len", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            check("t4_wrap_addr", wlog[i].addr, (65534 + i) % 65536);

        // Reset in the middle of a burst
        reset_dut();
        en[0] = 1;
        post(0, 500, 32, 0);
        n = 0;
        while (wcnt[0] < 5 && n < 100) begin cycle(); n++; end
        check("t5_reached_5", wcnt[0], 5);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_en", bram_en, 0);
        check("t5_rst_we", bram_we, 0);
        check("t5_rst_addr", bram_addr, 0);
        check("t5_rst_din", bram_din, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_tready", s_tready, 0);
        len_m[0] = 0;
        n = total_writes;
        run(3);
        rst = 1'b0;
        check("t5_cmd_ready", cmd_ready, 2'b11);
        run(6);
        check("t5_no_more_writes", total_writes, n);
        check("t5_busy", busy, 0);

        // Stalled grant with the other channel waiting
        reset_dut();
        en = '{1, 1};
        post(0, 1000, 40, 0);
        post(1, 2000, 8, 0);
        n = 0;
        while (idx[0] < 5 && n < 100) begin cycle(); n++; end
        en[0] = 0;
        run(20);
        en[0] = 1;
        wait_done(0, 1, 500);
        wait_done(1, 1, 500);
        run(2);
        check("t6_len", wlog.size(), 48);
        if (wlog.size() == 48) begin
`ifdef BRAM_WR_SCHED_YIELD_EN
            check("t6_yield_to_ch1", wlog[5].ch, 1);
            cnt = -1;
            for (int i = 47; i >= 5; i--) if (wlog[i].ch == 0) cnt = wlog[i].addr;
            check("t6_resume_addr", cnt, 1005);
`else
            cnt = 0;
            for (int i = 0; i < 16; i++) if (wlog[i].ch == 0) cnt++;
            check("t6_grant_held", cnt, 16);
            check("t6_then_ch1", wlog[16].ch, 1);
`endif
        end

        // Randomized commands and producer throttling
        for (int r = 0; r < 10; r++) begin
            pct[0] = $urandom_range(100, 30);
            pct[1] = $urandom_range(100, 30);
            en = '{1, 1};
            l0 = $urandom_range(50);
            l1 = $urandom_range(50);
            t0 = done_cnt[0] + 1;
            t1 = done_cnt[1] + 1;
            post(0, $urandom_range(65535), l0, 0);
            run($urandom_range(10));
            post(1, $urandom_range(65535), l1, 0);
            wait_done(0, t0, 3000);
            wait_done(1, t1, 3000);
            run(2);
            check("rnd_wcnt0", wcnt[0], l0);
            check("rnd_wcnt1", wcnt[1], l1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
